// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_STEP   = 4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads one word per grant from a combinational ROM
// and hands it to decode over valid/ready, honouring redirects and trapping misaligned targets.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_gnt,
    output logic              bus_rd,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fault
);

    // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
    // instr/instr_pc hold steady while valid is up and ready is low.

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              valid_q;
    logic              fault_q;
    logic              redirect_ok;

    assign redirect_ok = (redirect_pc[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ: begin
                if (redirect_valid) begin
                    state_d = redirect_ok ? REQ : FAULT;
                end else if (bus_gnt) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    state_d = redirect_ok ? REQ : FAULT;
                end else if (valid_q && instr_ready) begin
                    state_d = REQ;
                end
            end
            default: state_d = FAULT;
        endcase
    end

    // Redirect suppresses the read so a stale word is never latched in the same cycle.
    always_comb begin
        bus_rd   = (state_q == REQ) && bus_gnt && !redirect_valid;
        bus_addr = pc_q >> 2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else if (state_q == FAULT) begin
            valid_q <= 1'b0;
        end else if (redirect_valid) begin
            valid_q <= 1'b0;
            if (redirect_ok) begin
                pc_q <= redirect_pc;
            end else begin
                fault_q <= 1'b1;
            end
        end else if (state_q == REQ && bus_gnt) begin
            instr_q    <= bus_data;
            instr_pc_q <= pc_q;
            pc_q       <= pc_q + ADDR_W'(PC_STEP);
            valid_q    <= 1'b1;
        end else if (state_q == HOLD && valid_q && instr_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fault       = fault_q;

    a_rd_only_when_owned: assert property (@(posedge clk) disable iff (rst)
        bus_rd |-> (state_q == REQ && bus_gnt && !redirect_valid));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit against a slot-based reference model with a scoreboard.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, bus_gnt, bus_rd, instr_valid, instr_ready, redirect_valid, fault;
    logic [31:0] bus_addr, bus_data, instr, instr_pc, redirect_pc;

    logic        w_rst, w_gnt, w_rd, w_valid, w_ready, w_fault;
    logic [31:0] w_addr, w_data, w_instr, w_ipc;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    bit          mon_en = 1'b0;

    // reference model: current PC, whether an instruction occupies the output slot, sticky fault
    logic [31:0] m_pc;
    bit          m_hold;
    bit          m_fault;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h0080_2283;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0013;
    endfunction

    assign bus_data = bus_rd ? mem_word(bus_addr) : 32'hxxxx_xxxx;
    assign w_data   = w_rd ? mem_word(w_addr) : 32'hxxxx_xxxx;

    fetch_unit dut (
        .clk(clk), .rst(rst), .bus_gnt(bus_gnt), .bus_rd(bus_rd), .bus_addr(bus_addr),
        .bus_data(bus_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .fault(fault)
    );

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(w_rst), .bus_gnt(w_gnt), .bus_rd(w_rd), .bus_addr(w_addr),
        .bus_data(w_data), .instr_valid(w_valid), .instr_ready(w_ready),
        .instr(w_instr), .instr_pc(w_ipc), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .fault(w_fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs mid-cycle, check combinational and registered outputs, advance model.
    task automatic step(input bit r, input bit g, input bit rdy, input bit rv, input logic [31:0] rp);
        bit exp_rd;
        @(negedge clk);
        rst = r; bus_gnt = g; instr_ready = rdy; redirect_valid = rv; redirect_pc = rp;
        #1;
        exp_rd = !m_fault && !m_hold && g && !rv;
        check("bus_rd", {31'd0, bus_rd}, {31'd0, exp_rd});
        check("bus_addr", bus_addr, m_pc / 4);
        check("instr_valid", {31'd0, instr_valid}, {31'd0, m_hold});
        check("fault", {31'd0, fault}, {31'd0, m_fault});
        if (exp_rd && !r) exp_q.push_back({m_pc, mem_word(m_pc / 4)});
        if (r) begin
            m_pc = 32'h0; m_hold = 0; m_fault = 0;
        end else if (m_fault) begin
        end else if (rv) begin
            m_hold = 0;
            if (rp % 4 != 0) m_fault = 1;
            else m_pc = rp;
        end else if (!m_hold) begin
            if (g) begin
                m_hold = 1;
                m_pc = m_pc + 4;
            end
        end else if (rdy) begin
            m_hold = 0;
        end
    endtask

    task automatic w_cyc(input bit r, input bit g, input bit rdy);
        @(negedge clk);
        w_rst = r; w_gnt = g; w_ready = rdy;
        #1;
    endtask

    // Monitor: each newly presented instruction must match the scoreboard head and stay stable.
    logic        prev_v = 1'b0;
    logic [31:0] last_i, last_pc;
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                if (instr_valid && !prev_v) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL sb_empty: instr %08h presented with nothing expected", instr);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_instr", instr, e[31:0]);
                        check("sb_instr_pc", instr_pc, e[63:32]);
                        last_i = e[31:0];
                        last_pc = e[63:32];
                    end
                end else if (instr_valid && prev_v) begin
                    check("hold_instr", instr, last_i);
                    check("hold_pc", instr_pc, last_pc);
                end
                prev_v = instr_valid;
            end
        end
    end

    initial begin
        int r;
        rst = 1; bus_gnt = 0; instr_ready = 0; redirect_valid = 0; redirect_pc = 0;
        w_rst = 1; w_gnt = 0; w_ready = 0;
        repeat (2) @(posedge clk);
        m_pc = 0; m_hold = 0; m_fault = 0;
        @(negedge clk); #1;
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instr_pc", instr_pc, 32'h0);
        mon_en = 1;

        // first fetch, then handshake
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        // stall in HOLD for 5 cycles, then release
        repeat (5) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        // consume, then withhold grant
        step(0, 0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // redirect to 0x20 while holding with ready high
        step(0, 0, 1, 1, 32'h20);
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        // misaligned redirect traps until reset
        step(0, 1, 0, 1, 32'h22);
        repeat (10) step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 32'h40);
        step(1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        check("rst2_instr", instr, 32'h0000_0013);
        check("rst2_instr_pc", instr_pc, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            bit rr, gg, dd, vv;
            logic [31:0] pp;
            rr = ($urandom_range(0, 59) == 0);
            gg = ($urandom_range(0, 3) != 0);
            dd = ($urandom_range(0, 9) < 7);
            vv = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 7);
            pp = (r == 0) ? (32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3)))
                          : (32'($urandom_range(0, 255)) * 4);
            step(rr, gg, dd, vv, pp);
        end
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // wrap instance: reset PC at the top of the address space
        w_cyc(0, 1, 0);
        check("w_rd", {31'd0, w_rd}, 32'd1);
        check("w_addr", w_addr, 32'h3FFF_FFFF);
        w_cyc(0, 0, 0);
        check("w_valid", {31'd0, w_valid}, 32'd1);
        check("w_ipc", w_ipc, 32'hFFFF_FFFC);
        check("w_instr", w_instr, mem_word(32'h3FFF_FFFF));
        check("w_rd_hold", {31'd0, w_rd}, 32'd0);
        w_cyc(0, 0, 1);
        w_cyc(0, 1, 0);
        check("w_valid_drop", {31'd0, w_valid}, 32'd0);
        check("w_addr_wrap", w_addr, 32'h0);
        check("w_rd_wrap", {31'd0, w_rd}, 32'd1);
        w_cyc(1, 0, 0);
        check("w_valid2", {31'd0, w_valid}, 32'd1);
        check("w_ipc2", w_ipc, 32'h0);
        w_cyc(0, 0, 0);
        check("w_rst_valid", {31'd0, w_valid}, 32'd0);
        check("w_rst_instr", w_instr, 32'h0000_0013);
        check("w_rst_ipc", w_ipc, 32'h0);
        check("w_rst_addr", w_addr, 32'h3FFF_FFFF);
        check("w_rst_fault", {31'd0, w_fault}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
